// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead per stage,
// valid/ready stream with a single global advance enable.
module cla_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    input  logic             SUB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C_out,
    output logic             OVF
);
    localparam int NSTG = WIDTH / BLOCK;

    // Flattened sum-of-products carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
    function automatic logic [BLOCK:0] cla_carries(
        input logic [BLOCK-1:0] g,
        input logic [BLOCK-1:0] p,
        input logic             cin
    );
        logic [BLOCK:0] c;
        logic           t;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < BLOCK; i++) begin
            t = cin;
            for (int j = 0; j <= i; j++) t = t & p[j];
            c[i+1] = t;
            for (int j = 0; j <= i; j++) begin
                t = g[j];
                for (int k = j + 1; k <= i; k++) t = t & p[k];
                c[i+1] = c[i+1] | t;
            end
        end
        return c;
    endfunction

    logic             w_adv;
    logic [WIDTH-1:0] w_a   [NSTG];
    logic [WIDTH-1:0] w_b   [NSTG];
    logic [WIDTH-1:0] w_s   [NSTG];
    logic             w_cin [NSTG];
    logic             w_v   [NSTG];

    logic             r_out_valid;
    logic [WIDTH-1:0] r_s;
    logic             r_c_out;
    logic             r_ovf;

    assign w_adv     = !r_out_valid || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign S         = r_s;
    assign C_out     = r_c_out;
    assign OVF       = r_ovf;

    // Stage 0 sees the ports directly; B is inverted here so later stages never look at SUB.
    assign w_a[0]   = A;
    assign w_b[0]   = SUB ? ~B : B;
    assign w_s[0]   = '0;
    assign w_cin[0] = SUB ? 1'b1 : C_in;
    assign w_v[0]   = in_valid;

    genvar gi;
    generate
        for (gi = 0; gi < NSTG; gi++) begin : g_stg
            localparam int LO = gi * BLOCK;

            logic [BLOCK-1:0] w_g;
            logic [BLOCK-1:0] w_p;
            logic [BLOCK:0]   w_c;
            logic [WIDTH-1:0] w_sum;

            assign w_g = w_a[gi][LO +: BLOCK] & w_b[gi][LO +: BLOCK];
            assign w_p = w_a[gi][LO +: BLOCK] ^ w_b[gi][LO +: BLOCK];
            assign w_c = cla_carries(w_g, w_p, w_cin[gi]);

            always_comb begin
                w_sum               = w_s[gi];
                w_sum[LO +: BLOCK]  = w_p ^ w_c[BLOCK-1:0];
            end

            if (gi < NSTG - 1) begin : g_mid
                logic             r_v;
                logic             r_c;
                logic [WIDTH-1:0] r_a;
                logic [WIDTH-1:0] r_b;
                logic [WIDTH-1:0] r_sum;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_v   <= 1'b0;
                        r_c   <= 1'b0;
                        r_a   <= '0;
                        r_b   <= '0;
                        r_sum <= '0;
                    end else if (w_adv) begin
                        r_v   <= w_v[gi];
                        r_c   <= w_c[BLOCK];
                        r_a   <= w_a[gi];
                        r_b   <= w_b[gi];
                        r_sum <= w_sum;
                    end
                end

                assign w_v[gi+1]   = r_v;
                assign w_cin[gi+1] = r_c;
                assign w_a[gi+1]   = r_a;
                assign w_b[gi+1]   = r_b;
                assign w_s[gi+1]   = r_sum;
            end else begin : g_last
                // The last stage's registers are the output registers.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_out_valid <= 1'b0;
                        r_s         <= '0;
                        r_c_out     <= 1'b0;
                        r_ovf       <= 1'b0;
                    end else if (w_adv) begin
                        r_out_valid <= w_v[gi];
                        r_s         <= w_sum;
                        r_c_out     <= w_c[BLOCK];
                        r_ovf       <= w_c[BLOCK] ^ w_c[BLOCK-1];
                    end
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed and seeded-random checks of cla_pipe_adder in three configurations:
// 8/4 (two stages), 32/8 (four stages) and 16/16 (single stage).
module tb_cla_pipe_adder;
    logic clk;
    logic rst_n;

    logic        iv8, ir8, or8, cin8, sub8, ov8, co8, ovf8;
    logic [7:0]  a8, b8, s8;
    logic        iv32, ir32, or32, cin32, sub32, ov32, co32, ovf32;
    logic [31:0] a32, b32, s32;
    logic        iv16, ir16, or16, cin16, sub16, ov16, co16, ovf16;
    logic [15:0] a16, b16, s16;

    int n_pass  = 0;
    int n_total = 0;

    cla_pipe_adder #(.WIDTH(8), .BLOCK(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .A(a8), .B(b8), .C_in(cin8), .SUB(sub8),
        .out_valid(ov8), .out_ready(or8), .S(s8), .C_out(co8), .OVF(ovf8)
    );

    cla_pipe_adder #(.WIDTH(32), .BLOCK(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
        .A(a32), .B(b32), .C_in(cin32), .SUB(sub32),
        .out_valid(ov32), .out_ready(or32), .S(s32), .C_out(co32), .OVF(ovf32)
    );

    cla_pipe_adder #(.WIDTH(16), .BLOCK(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .A(a16), .B(b16), .C_in(cin16), .SUB(sub16),
        .out_valid(ov16), .out_ready(or16), .S(s16), .C_out(co16), .OVF(ovf16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns {OVF, C_out, S} from plain wide arithmetic and the sign rule.
    function automatic logic [33:0] ref32(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        logic [31:0] be;
        logic [32:0] t;
        logic        ovf;
        be  = sub ? ~b : b;
        t   = {1'b0, a} + {1'b0, be} + {32'd0, (sub ? 1'b1 : cin)};
        ovf = (a[31] == be[31]) && (t[31] != a[31]);
        return {ovf, t[32], t[31:0]};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        iv8 = 0; or8 = 1; a8 = '0; b8 = '0; cin8 = 0; sub8 = 0;
        iv32 = 0; or32 = 1; a32 = '0; b32 = '0; cin32 = 0; sub32 = 0;
        iv16 = 0; or16 = 1; a16 = '0; b16 = '0; cin16 = 0; sub16 = 0;
        #2;
        n_total++;
        if ({ov8, co8, ovf8, s8} !== 11'd0) $display("FAIL reset8: got %h expected 0", {ov8, co8, ovf8, s8});
        else n_pass++;
        n_total++;
        if ({ov32, co32, ovf32, s32} !== 35'd0) $display("FAIL reset32: got %h expected 0", {ov32, co32, ovf32, s32});
        else n_pass++;
        n_total++;
        if ({ov16, co16, ovf16, s16} !== 19'd0) $display("FAIL reset16: got %h expected 0", {ov16, co16, ovf16, s16});
        else n_pass++;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        n_total++;
        if ({ir8, ir32, ir16} !== 3'b111) $display("FAIL reset_in_ready: got %b expected 111", {ir8, ir32, ir16});
        else n_pass++;
        $display("txn reset released, in_ready=%b%b%b", ir8, ir32, ir16);
    endtask

    task automatic test_add_basic();
        a8 = 8'h3C; b8 = 8'h45; cin8 = 1; sub8 = 0; iv8 = 1;
        tick();
        iv8 = 0;
        n_total++;
        if (ov8 !== 1'b0) $display("FAIL add_early_valid: got %b expected 0", ov8);
        else n_pass++;
        tick();
        $display("txn dut8 3C+45+1 -> S=%h C_out=%b OVF=%b", s8, co8, ovf8);
        n_total++;
        if ({ov8, co8, ovf8, s8} !== {1'b1, 1'b0, 1'b1, 8'h82})
            $display("FAIL add_basic: got %h expected %h", {ov8, co8, ovf8, s8}, {1'b1, 1'b0, 1'b1, 8'h82});
        else n_pass++;
        tick();
        n_total++;
        if (ov8 !== 1'b0) $display("FAIL add_single_result: got out_valid=%b expected 0", ov8);
        else n_pass++;
    endtask

    task automatic test_wrap_sub();
        logic [10:0] exp8 [3];
        exp8[0] = {1'b1, 1'b1, 1'b0, 8'h00};
        exp8[1] = {1'b1, 1'b0, 1'b0, 8'hFE};
        exp8[2] = {1'b1, 1'b1, 1'b0, 8'h00};
        a8 = 8'hFF; b8 = 8'h01; cin8 = 0; sub8 = 0; iv8 = 1;
        tick();
        a8 = 8'h05; b8 = 8'h07; cin8 = 1; sub8 = 1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                a8 = 8'h9A; b8 = 8'h9A; cin8 = 0; sub8 = 1;
            end else if (i == 2) begin
                iv8 = 0;
            end
            tick();
            $display("txn dut8 wrap/sub %0d -> S=%h C_out=%b OVF=%b", i, s8, co8, ovf8);
            n_total++;
            if ({ov8, co8, ovf8, s8} !== exp8[i])
                $display("FAIL wrap_sub_%0d: got %h expected %h", i, {ov8, co8, ovf8, s8}, exp8[i]);
            else n_pass++;
        end
    endtask

    task automatic test_streaming();
        logic [33:0] exp_r [100];
        void'($urandom(1));
        for (int n = 1; n <= 103; n++) begin
            if (n <= 100) begin
                if (n == 51) void'($urandom(2));
                a32 = $urandom(); b32 = $urandom();
                cin32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
                iv32 = 1;
                exp_r[n-1] = ref32(a32, b32, cin32, sub32);
            end else begin
                iv32 = 0;
            end
            n_total++;
            if (ir32 !== 1'b1) $display("FAIL stream_in_ready cycle %0d: got %b expected 1", n, ir32);
            else n_pass++;
            tick();
            n_total++;
            if (n >= 4) begin
                $display("txn dut32 stream %0d -> S=%h C_out=%b OVF=%b", n - 4, s32, co32, ovf32);
                if ({ov32, ovf32, co32, s32} !== {1'b1, exp_r[n-4]})
                    $display("FAIL stream_%0d: got %h expected %h", n - 4, {ov32, ovf32, co32, s32}, {1'b1, exp_r[n-4]});
                else n_pass++;
            end else begin
                if (ov32 !== 1'b0) $display("FAIL stream_latency cycle %0d: got out_valid=%b expected 0", n, ov32);
                else n_pass++;
            end
        end
        tick();
        n_total++;
        if (ov32 !== 1'b0) $display("FAIL stream_drained: got out_valid=%b expected 0", ov32);
        else n_pass++;
    endtask

    task automatic test_back_pressure();
        logic [31:0] sum_bp [6];
        sum_bp[0] = 32'h01010101; sum_bp[1] = 32'h12121212; sum_bp[2] = 32'h23232323;
        sum_bp[3] = 32'h34343434; sum_bp[4] = 32'h45454545; sum_bp[5] = 32'h56565656;
        b32 = 32'h01010101; cin32 = 0; sub32 = 0; or32 = 1;
        for (int i = 0; i < 4; i++) begin
            a32 = 32'h11111111 * i; iv32 = 1;
            tick();
        end
        or32 = 0;
        a32 = 32'h44444444; iv32 = 1;
        #1;
        for (int k = 0; k < 5; k++) begin
            n_total++;
            if (ir32 !== 1'b0) $display("FAIL bp_in_ready_%0d: got %b expected 0", k, ir32);
            else n_pass++;
            tick();
            n_total++;
            if ({ov32, co32, ovf32, s32} !== {3'b100, sum_bp[0]})
                $display("FAIL bp_hold_%0d: got %h expected %h", k, {ov32, co32, ovf32, s32}, {3'b100, sum_bp[0]});
            else n_pass++;
        end
        $display("txn dut32 stalled result S=%h transferred on release", s32);
        or32 = 1;
        #1;
        n_total++;
        if (ir32 !== 1'b1) $display("FAIL bp_release_ready: got %b expected 1", ir32);
        else n_pass++;
        for (int j = 1; j <= 5; j++) begin
            tick();
            if (j == 1) a32 = 32'h55555555;
            else iv32 = 0;
            $display("txn dut32 drain %0d -> S=%h", j, s32);
            n_total++;
            if ({ov32, co32, ovf32, s32} !== {3'b100, sum_bp[j]})
                $display("FAIL bp_drain_%0d: got %h expected %h", j, {ov32, co32, ovf32, s32}, {3'b100, sum_bp[j]});
            else n_pass++;
        end
        tick();
        n_total++;
        if (ov32 !== 1'b0) $display("FAIL bp_no_duplicate: got out_valid=%b expected 0", ov32);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        or32 = 1; cin32 = 0; sub32 = 0;
        a32 = 32'h80000001; b32 = 32'h80000001; iv32 = 1;
        tick();
        for (int i = 1; i < 4; i++) begin
            a32 = 32'h01000000 * i; b32 = 32'h00000303; iv32 = 1;
            tick();
        end
        iv32 = 0;
        n_total++;
        if ({ov32, co32, ovf32, s32} !== {3'b111, 32'h00000002})
            $display("FAIL rst_pre: got %h expected %h", {ov32, co32, ovf32, s32}, {3'b111, 32'h00000002});
        else n_pass++;
        #3;
        rst_n = 1'b0;
        #1;
        $display("txn dut32 async reset mid-stream -> out_valid=%b S=%h", ov32, s32);
        n_total++;
        if ({ov32, co32, ovf32, s32} !== 35'd0)
            $display("FAIL rst_immediate: got %h expected 0", {ov32, co32, ovf32, s32});
        else n_pass++;
        tick();
        rst_n = 1'b1;
        #1;
        n_total++;
        if (ir32 !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", ir32);
        else n_pass++;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_total++;
            if (ov32 !== 1'b0) $display("FAIL rst_stale_%0d: got out_valid=%b expected 0", k, ov32);
            else n_pass++;
        end
    endtask

    task automatic test_single_stage();
        a16 = 16'h7FFF; b16 = 16'h0001; cin16 = 0; sub16 = 0; iv16 = 1; or16 = 1;
        tick();
        a16 = 16'h1234; b16 = 16'h1234; cin16 = 1; sub16 = 1;
        $display("txn dut16 7FFF+0001 -> S=%h C_out=%b OVF=%b", s16, co16, ovf16);
        n_total++;
        if ({ov16, co16, ovf16, s16} !== {1'b1, 1'b0, 1'b1, 16'h8000})
            $display("FAIL single_add: got %h expected %h", {ov16, co16, ovf16, s16}, {1'b1, 1'b0, 1'b1, 16'h8000});
        else n_pass++;
        tick();
        iv16 = 0;
        $display("txn dut16 1234-1234 -> S=%h C_out=%b OVF=%b", s16, co16, ovf16);
        n_total++;
        if ({ov16, co16, ovf16, s16} !== {1'b1, 1'b1, 1'b0, 16'h0000})
            $display("FAIL single_sub_equal: got %h expected %h", {ov16, co16, ovf16, s16}, {1'b1, 1'b1, 1'b0, 16'h0000});
        else n_pass++;
        tick();
        n_total++;
        if (ov16 !== 1'b0) $display("FAIL single_empty: got out_valid=%b expected 0", ov16);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_wrap_sub();
        test_streaming();
        test_back_pressure();
        test_reset_midstream();
        test_single_stage();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
